// File: rtl/delta_adc_seq_if.sv
// Result channel of the delta ADC sequencer: one captured loop value per channel visit.
// Ports: res_valid/res_data/res_chan driven by the sequencer, res_ready by the consumer.
// A result is held unchanged until the cycle where res_valid && res_ready.
interface delta_adc_seq_if #(
  parameter int W  = 16,
  parameter int CW = 2
);
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic [CW-1:0] res_chan;

  modport master (output res_valid, res_data, res_chan, input res_ready);
  modport slave  (input res_valid, res_data, res_chan, output res_ready);
endinterface

// File: rtl/delta_adc_seq.sv
// Delta ADC channel sequencer: walks enabled mux channels, presets the loop register from
// the channel's stored value, waits SETTLE_CYCLES, lets the loop run for STEPS strobes and
// returns the loop value. Latency per channel: 1 load + SETTLE_CYCLES + STEPS strobes + 1
// capture cycle. Backpressure: holds the result (and the whole scan) until res_ready.
// Ports: clk, reset (async active-low), start/cont/abort/ch_enable scan control,
// sampling_strb/adc_value_i from the loop, chan_sel/loop_load/loop_load_value/loop_run to
// the loop, busy status, res result handshake (master side).
module delta_adc_seq #(
  parameter  int W             = 16,
  parameter  int NCH           = 4,
  parameter  int SETTLE_CYCLES = 8,
  parameter  int STEPS         = 16,
  localparam int CW            = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           cont,
  input  logic           abort,
  input  logic [NCH-1:0] ch_enable,
  input  logic           sampling_strb,
  input  logic [W-1:0]   adc_value_i,
  output logic [CW-1:0]  chan_sel,
  output logic           loop_load,
  output logic [W-1:0]   loop_load_value,
  output logic           loop_run,
  output logic           busy,
  delta_adc_seq_if.master res
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(STEPS + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, TRACK, CAPTURE, OUTPUT} state_t;

  state_t         state;
  logic [W-1:0]   stored [NCH];
  logic [NCH-1:0] mask_q;
  logic           cont_q;
  logic [SW-1:0]  settle_cnt;
  logic [TW-1:0]  step_cnt;
  logic           valid_q;
  logic [W-1:0]   data_q;
  logic [CW-1:0]  chan_q;

  // {found, index} of the lowest set bit of m at or above position 'from'.
  function automatic logic [CW:0] pick(input logic [NCH-1:0] m, input int from);
    logic [CW:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && i >= from) r = {1'b1, CW'(i)};
    end
    return r;
  endfunction

  logic [CW:0]   first_new;
  logic [CW:0]   next_hi;
  logic          load_go;
  logic          wrap;
  logic [CW-1:0] load_idx;

  always_comb begin
    first_new = pick(ch_enable, 0);
    next_hi   = pick(mask_q, int'(chan_sel) + 1);
    load_go   = 1'b0;
    wrap      = 1'b0;
    load_idx  = first_new[CW-1:0];
    if (state == IDLE) begin
      load_go = start && first_new[CW];
    end else if (state == OUTPUT && res.res_ready) begin
      if (next_hi[CW]) begin
        load_go  = 1'b1;
        load_idx = next_hi[CW-1:0];
      end else if (cont_q) begin
        // end of pass in continuous mode: restart from the freshly sampled mask
        wrap    = 1'b1;
        load_go = first_new[CW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      chan_sel        <= '0;
      loop_load       <= 1'b0;
      loop_load_value <= '0;
      loop_run        <= 1'b0;
      busy            <= 1'b0;
      valid_q         <= 1'b0;
      data_q          <= '0;
      chan_q          <= '0;
      mask_q          <= '0;
      cont_q          <= 1'b0;
      settle_cnt      <= '0;
      step_cnt        <= '0;
      for (int i = 0; i < NCH; i++) stored[i] <= {1'b1, {(W-1){1'b0}}};
    end else if (abort) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      loop_run  <= 1'b0;
      loop_load <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_go) begin
            mask_q <= ch_enable;
            cont_q <= cont;
          end
        end
        LOAD: begin
          loop_load <= 1'b0;
          state     <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            state    <= TRACK;
            loop_run <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        TRACK: begin
          // loop_run stays high through the STEPS-th strobe so that step is applied
          if (sampling_strb) begin
            if (step_cnt == TW'(STEPS - 1)) begin
              state    <= CAPTURE;
              loop_run <= 1'b0;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        CAPTURE: begin
          stored[chan_sel] <= adc_value_i;
          data_q           <= adc_value_i;
          chan_q           <= chan_sel;
          valid_q          <= 1'b1;
          state            <= OUTPUT;
        end
        OUTPUT: begin
          if (res.res_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
            busy    <= 1'b0;
            if (wrap) mask_q <= ch_enable;
          end
        end
        default: state <= IDLE;
      endcase
      // Entering LOAD (from IDLE or after a handshake) overrides the case defaults above.
      if (load_go) begin
        state           <= LOAD;
        chan_sel        <= load_idx;
        loop_load       <= 1'b1;
        loop_load_value <= stored[load_idx];
        busy            <= 1'b1;
        settle_cnt      <= '0;
        step_cnt        <= '0;
      end
    end
  end

  assign res.res_valid = valid_q;
  assign res.res_data  = data_q;
  assign res.res_chan  = chan_q;
endmodule
